// File: rtl/wallet.sv
// Signed-magnitude BCD balance keeper: serves billing charges and runs the
// three-button deposit-entry dialogue, with digit-serial BCD arithmetic.
module wallet #(
  parameter logic [11:0] INIT_BAL = 12'h196,
  parameter int unsigned TICK     = 100000000,
  parameter int unsigned EDIT_TO  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        on,
  input  logic        m_pos,
  input  logic        u_pos,
  input  logic        d_pos,
  input  logic        chg_req,
  input  logic [11:0] chg_amt,
  output logic [11:0] bal,
  output logic        bal_neg,
  output logic [11:0] dep,
  output logic [1:0]  dig_sel,
  output logic        editing,
  output logic        busy,
  output logic        chg_done
);

  localparam int unsigned LIMIT = EDIT_TO * TICK;
  localparam int TW = $clog2(LIMIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_EDIT, S_CMP, S_D0, S_D1, S_D2, S_WB} state_t;

  state_t        state_reg, state_next;
  logic [11:0]   bal_reg, dep_reg, opnd_reg, a_reg, b_reg, res_reg;
  logic          bal_neg_reg, op_sub_reg, ret_edit_reg, sub_mode_reg;
  logic          sign_reg, carry_reg, chg_done_reg;
  logic [1:0]    dig_sel_reg;
  logic [TW-1:0] timer_reg;

  logic m_acc, u_acc, d_acc, any_btn, timeout;
  assign m_acc   = on & m_pos;
  assign u_acc   = on & u_pos;
  assign d_acc   = on & d_pos;
  assign any_btn = m_acc | u_acc | d_acc;
  assign timeout = (timer_reg == TW'(LIMIT - 1));

  // Per-digit helpers: charge clamping and wrap-around edit of the selected digit.
  logic [11:0] chg_clamp, dep_inc, dep_dec;
  for (genvar gi = 0; gi < 3; gi++) begin : g_dig
    logic [3:0] c_dig, e_dig;
    logic       sel;
    assign c_dig = chg_amt[gi*4 +: 4];
    assign e_dig = dep_reg[gi*4 +: 4];
    assign sel   = (dig_sel_reg == 2'(gi));
    assign chg_clamp[gi*4 +: 4] = (c_dig > 4'd9) ? 4'd9 : c_dig;
    assign dep_inc[gi*4 +: 4]   = !sel ? e_dig : (e_dig >= 4'd9) ? 4'd0 : e_dig + 4'd1;
    assign dep_dec[gi*4 +: 4]   = !sel ? e_dig : (e_dig == 4'd0) ? 4'd9 : e_dig - 4'd1;
  end

  // One BCD digit per arithmetic state, carry/borrow held in carry_reg.
  logic [3:0] a_dig, b_dig, r_dig;
  logic [4:0] sum5, dif5;
  logic       c_out;
  always_comb begin
    a_dig = a_reg[3:0];
    b_dig = b_reg[3:0];
    case (state_reg)
      S_D1: begin a_dig = a_reg[7:4];  b_dig = b_reg[7:4];  end
      S_D2: begin a_dig = a_reg[11:8]; b_dig = b_reg[11:8]; end
      default: ;
    endcase
    sum5 = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_reg};
    dif5 = {1'b0, a_dig} - {1'b0, b_dig} - {4'd0, carry_reg};
    if (sub_mode_reg) begin
      c_out = dif5[4];
      r_dig = dif5[4] ? dif5[3:0] + 4'd10 : dif5[3:0];
    end else begin
      c_out = (sum5 > 5'd9);
      r_dig = c_out ? sum5[3:0] - 4'd10 : sum5[3:0];
    end
  end

  logic opnd_neg, same_sign, bal_ge, wb_neg;
  logic [11:0] wb_mag;
  assign opnd_neg  = op_sub_reg;
  assign same_sign = (bal_neg_reg == opnd_neg);
  assign bal_ge    = (bal_reg >= opnd_reg);
  assign wb_mag    = (!sub_mode_reg && carry_reg) ? 12'h999 : res_reg;
  assign wb_neg    = (wb_mag != 12'h000) && sign_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (chg_req)    state_next = S_CMP;
        else if (m_acc) state_next = S_EDIT;
      end
      S_EDIT: begin
        if (chg_req)                            state_next = S_CMP;
        else if (m_acc && dig_sel_reg == 2'd2)  state_next = S_CMP;
        else if (!any_btn && timeout)           state_next = S_IDLE;
      end
      S_CMP:   state_next = S_D0;
      S_D0:    state_next = S_D1;
      S_D1:    state_next = S_D2;
      S_D2:    state_next = S_WB;
      S_WB:    state_next = ret_edit_reg ? S_EDIT : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_reg == S_CMP) || (state_reg == S_D0) || (state_reg == S_D1) ||
              (state_reg == S_D2)  || (state_reg == S_WB);
    editing = (state_reg == S_EDIT);
  end

  assign bal      = bal_reg;
  assign bal_neg  = bal_neg_reg;
  assign dep      = dep_reg;
  assign dig_sel  = dig_sel_reg;
  assign chg_done = chg_done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bal_reg      <= INIT_BAL;
      bal_neg_reg  <= 1'b0;
      dep_reg      <= '0;
      dig_sel_reg  <= '0;
      timer_reg    <= '0;
      chg_done_reg <= 1'b0;
      opnd_reg     <= '0;
      op_sub_reg   <= 1'b0;
      ret_edit_reg <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      res_reg      <= '0;
      sub_mode_reg <= 1'b0;
      sign_reg     <= 1'b0;
      carry_reg    <= 1'b0;
    end else begin
      chg_done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (chg_req) begin
            opnd_reg     <= chg_clamp;
            op_sub_reg   <= 1'b1;
            ret_edit_reg <= 1'b0;
          end else if (m_acc) begin
            dep_reg     <= '0;
            dig_sel_reg <= '0;
            timer_reg   <= '0;
          end
        end
        S_EDIT: begin
          if (chg_req) begin
            opnd_reg     <= chg_clamp;
            op_sub_reg   <= 1'b1;
            ret_edit_reg <= 1'b1;
          end else if (m_acc) begin
            timer_reg <= '0;
            if (dig_sel_reg == 2'd2) begin
              opnd_reg     <= dep_reg;
              op_sub_reg   <= 1'b0;
              ret_edit_reg <= 1'b0;
            end else begin
              dig_sel_reg <= dig_sel_reg + 2'd1;
            end
          end else if (u_acc) begin
            timer_reg <= '0;
            dep_reg   <= dep_inc;
          end else if (d_acc) begin
            timer_reg <= '0;
            dep_reg   <= dep_dec;
          end else if (timeout) begin
            timer_reg   <= '0;
            dep_reg     <= '0;
            dig_sel_reg <= '0;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        S_CMP: begin
          carry_reg <= 1'b0;
          res_reg   <= '0;
          // Mixed signs always subtract the smaller magnitude from the larger.
          if (same_sign) begin
            a_reg <= bal_reg;  b_reg <= opnd_reg; sub_mode_reg <= 1'b0; sign_reg <= bal_neg_reg;
          end else if (bal_ge) begin
            a_reg <= bal_reg;  b_reg <= opnd_reg; sub_mode_reg <= 1'b1; sign_reg <= bal_neg_reg;
          end else begin
            a_reg <= opnd_reg; b_reg <= bal_reg;  sub_mode_reg <= 1'b1; sign_reg <= opnd_neg;
          end
        end
        S_D0: begin res_reg[3:0]  <= r_dig; carry_reg <= c_out; end
        S_D1: begin res_reg[7:4]  <= r_dig; carry_reg <= c_out; end
        S_D2: begin res_reg[11:8] <= r_dig; carry_reg <= c_out; end
        S_WB: begin
          bal_reg     <= wb_mag;
          bal_neg_reg <= wb_neg;
          if (op_sub_reg) begin
            chg_done_reg <= 1'b1;
          end else begin
            dep_reg     <= '0;
            dig_sel_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wallet.sv
// Directed bench for wallet: an integer balance model feeds a scoreboard queue
// that is drained and compared whenever an arithmetic operation completes.
module tb_wallet;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        on = 1'b1;
  logic        m_pos = 1'b0, u_pos = 1'b0, d_pos = 1'b0, chg_req = 1'b0;
  logic [11:0] chg_amt = '0;
  logic [11:0] bal, dep;
  logic        bal_neg, editing, busy, chg_done;
  logic [1:0]  dig_sel;

  wallet #(.INIT_BAL(12'h196), .TICK(4), .EDIT_TO(8)) dut (
    .clk(clk), .rst(rst), .on(on), .m_pos(m_pos), .u_pos(u_pos), .d_pos(d_pos),
    .chg_req(chg_req), .chg_amt(chg_amt), .bal(bal), .bal_neg(bal_neg), .dep(dep),
    .dig_sel(dig_sel), .editing(editing), .busy(busy), .chg_done(chg_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [11:0] bal; logic neg; logic done; } exp_t;
  exp_t sbq[$];
  int n_pass = 0, n_fail = 0, n_total = 0;
  int bal_m = 196;

  function automatic int bcd2i(input logic [11:0] b);
    int h, t, u;
    h = (b[11:8] > 4'd9) ? 9 : int'(b[11:8]);
    t = (b[7:4]  > 4'd9) ? 9 : int'(b[7:4]);
    u = (b[3:0]  > 4'd9) ? 9 : int'(b[3:0]);
    return h * 100 + t * 10 + u;
  endfunction

  function automatic logic [11:0] i2bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input int delta, input logic is_chg);
    int nb;
    exp_t e;
    nb = bal_m + delta;
    if (nb > 999)  nb = 999;
    if (nb < -999) nb = -999;
    bal_m  = nb;
    e.bal  = i2bcd(nb < 0 ? -nb : nb);
    e.neg  = (nb < 0);
    e.done = is_chg;
    sbq.push_back(e);
  endtask

  // Entered at the negedge after the sampling edge plus (5 - lat) cycles.
  task automatic wait_done(input string tag, input int lat);
    int cyc;
    exp_t e;
    chk({tag, " busy_start"}, 32'(busy), 32'd1);
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(lat));
    chk({tag, " sb_depth"}, 32'(sbq.size()), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, " bal"}, 32'(bal), 32'(e.bal));
      chk({tag, " bal_neg"}, 32'(bal_neg), 32'(e.neg));
      chk({tag, " chg_done"}, 32'(chg_done), 32'(e.done));
    end
    @(negedge clk);
    chk({tag, " chg_done_drop"}, 32'(chg_done), 32'd0);
    $display("op %s: bal=%03h neg=%0d", tag, bal, bal_neg);
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    @(negedge clk);
    m_pos = m; u_pos = u; d_pos = d;
    @(negedge clk);
    m_pos = 1'b0; u_pos = 1'b0; d_pos = 1'b0;
  endtask

  task automatic charge(input string tag, input logic [11:0] amt, input logic with_m);
    push_op(-bcd2i(amt), 1'b1);
    @(negedge clk);
    chg_req = 1'b1; chg_amt = amt; m_pos = with_m;
    @(negedge clk);
    chg_req = 1'b0; m_pos = 1'b0;
    wait_done(tag, 5);
  endtask

  task automatic deposit(input string tag, input logic [11:0] amt);
    logic [11:0] a;
    a = amt;
    press(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat (int'(a[4*i +: 4])) press(1'b0, 1'b1, 1'b0);
      if (i < 2) press(1'b1, 1'b0, 1'b0);
    end
    push_op(bcd2i(amt), 1'b0);
    press(1'b1, 1'b0, 1'b0);
    wait_done(tag, 5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst bal", 32'(bal), 32'h196);
    chk("rst bal_neg", 32'(bal_neg), 32'd0);
    chk("rst dep", 32'(dep), 32'h000);
    chk("rst dig_sel", 32'(dig_sel), 32'd0);
    chk("rst editing", 32'(editing), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst chg_done", 32'(chg_done), 32'd0);
    rst = 1'b0;

    // Charges, debt and payoff.
    charge("chg045", 12'h045, 1'b0);
    charge("chg121", 12'h121, 1'b0);
    charge("chg045_debt", 12'h045, 1'b0);
    deposit("dep020_payoff", 12'h020);
    charge("chg005_zero", 12'h005, 1'b0);
    deposit("dep196", 12'h196);

    // Manual entry dialogue.
    press(1'b1, 1'b0, 1'b0);
    chk("entry editing", 32'(editing), 32'd1);
    repeat (3) press(1'b0, 1'b1, 1'b0);
    chk("entry dep003", 32'(dep), 32'h003);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    chk("entry dep093", 32'(dep), 32'h093);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    chk("entry dep193", 32'(dep), 32'h193);
    chk("entry dig_sel2", 32'(dig_sel), 32'd2);
    push_op(193, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    wait_done("entry_add", 5);
    chk("entry dep_clr", 32'(dep), 32'h000);
    chk("entry editing_clr", 32'(editing), 32'd0);
    chk("entry dig_sel_clr", 32'(dig_sel), 32'd0);

    // Saturation.
    deposit("dep511", 12'h511);
    deposit("dep250_sat", 12'h250);

    // Units wrap both ways, then idle timeout.
    press(1'b1, 1'b0, 1'b0);
    repeat (9) press(1'b0, 1'b1, 1'b0);
    chk("wrap dep009", 32'(dep), 32'h009);
    press(1'b0, 1'b1, 1'b0);
    chk("wrap up_to_000", 32'(dep), 32'h000);
    press(1'b0, 1'b0, 1'b1);
    chk("wrap down_to_009", 32'(dep), 32'h009);
    repeat (31) @(negedge clk);
    chk("timeout not_yet", 32'(editing), 32'd1);
    @(negedge clk);
    chk("timeout editing", 32'(editing), 32'd0);
    chk("timeout dep", 32'(dep), 32'h000);
    chk("timeout dig_sel", 32'(dig_sel), 32'd0);
    chk("timeout bal", 32'(bal), 32'h999);

    // chg_req and m_pos together in IDLE: the charge wins, m_pos is dropped.
    charge("chg_with_m", 12'h100, 1'b1);
    chk("collide editing", 32'(editing), 32'd0);

    // Charge in the middle of EDIT, with a clamped amount (0AF -> 099).
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    chk("midedit dep_before", 32'(dep), 32'h012);
    charge("chg_midedit", 12'h0AF, 1'b0);
    chk("midedit editing", 32'(editing), 32'd1);
    chk("midedit dep", 32'(dep), 32'h012);
    chk("midedit dig_sel", 32'(dig_sel), 32'd1);
    press(1'b1, 1'b0, 1'b0);
    push_op(12, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    wait_done("midedit_add", 5);

    // Second chg_req at E0+2 is ignored.
    push_op(-12, 1'b1);
    @(negedge clk); chg_req = 1'b1; chg_amt = 12'h012;
    @(negedge clk); chg_req = 1'b0;
    @(negedge clk); chg_req = 1'b1; chg_amt = 12'h500;
    @(negedge clk); chg_req = 1'b0;
    wait_done("chg_ignore", 3);
    repeat (6) @(negedge clk);
    chk("ignore busy", 32'(busy), 32'd0);
    chk("ignore bal", 32'(bal), 32'h800);

    // Asynchronous reset while in D1.
    push_op(-100, 1'b1);
    @(negedge clk); chg_req = 1'b1; chg_amt = 12'h100;
    @(negedge clk); chg_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst bal", 32'(bal), 32'h196);
    chk("arst bal_neg", 32'(bal_neg), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst chg_done", 32'(chg_done), 32'd0);
    chk("arst dep", 32'(dep), 32'h000);
    void'(sbq.pop_back());
    bal_m = 196;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst no_done", 32'(chg_done), 32'd0);
    chk("arst bal_hold", 32'(bal), 32'h196);
    charge("chg_after_rst", 12'h045, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
